// File: rtl/rob_commit_ctrl_if.sv
// Dispatcher / CDB / register-file bundle for the reorder-buffer controller.
// master: the side driving allocation requests and CDB results.
// slave: the reorder-buffer controller itself.
interface rob_commit_ctrl_if;
   // Allocation
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_is_branch;
   logic [4:0]  issue_tag;
   logic        rob_full;
   // Result broadcast
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        cdb_mispredict;
   logic [31:0] cdb_target;
   // Operand lookup
   logic [4:0]  query_tag;
   logic        query_ready;
   logic [31:0] query_data;
   // Commit to register file
   logic        rob_valid;
   logic [4:0]  dest;
   logic [4:0]  dest_depend;
   logic [31:0] rob_data;
   // Recovery
   logic        wrong_commit;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output issue_valid, issue_rd, issue_is_branch,
      output cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      output query_tag,
      input  issue_tag, rob_full, query_ready, query_data,
      input  rob_valid, dest, dest_depend, rob_data,
      input  wrong_commit, redirect_valid, redirect_pc
   );

   modport slave (
      input  issue_valid, issue_rd, issue_is_branch,
      input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict, cdb_target,
      input  query_tag,
      output issue_tag, rob_full, query_ready, query_data,
      output rob_valid, dest, dest_depend, rob_data,
      output wrong_commit, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: allocates rename tags, collects CDB results,
// retires in program order and sequences a one-cycle mispredict flush.
// Tag 0 means "no dependency"; entry i carries tag i+1.
module rob_commit_ctrl #(
   parameter int unsigned ROB_SIZE = 16,
   parameter int unsigned IDX_W    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   rob_commit_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = IDX_W + 1;

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   // Per-entry flags (reset) and payload (no reset, only read when flagged)
   logic [ROB_SIZE-1:0] busy_q, ready_q, is_br_q, mispred_q;
   logic [4:0]          rd_q     [ROB_SIZE];
   logic [31:0]         data_q   [ROB_SIZE];
   logic [31:0]         target_q [ROB_SIZE];

   logic [IDX_W-1:0] head_q, tail_q, head_nxt, tail_nxt;
   logic [CNT_W-1:0] count_q;
   state_e           state_q, state_d;

   logic             alloc, commit, cdb_hit, flush;
   logic             cdb_in_range, query_in_range;
   logic [IDX_W-1:0] cdb_idx, query_idx;

   logic        rob_valid_q, wrong_commit_q, redirect_valid_q;
   logic [4:0]  dest_q, dest_depend_q;
   logic [31:0] rob_data_q, redirect_pc_q, flush_pc_q;
   logic        query_ready_c;
   logic [31:0] query_data_c;

   assign bus.issue_tag = 5'(tail_q) + 5'd1;
   assign bus.rob_full  = (count_q == CNT_W'(ROB_SIZE));

   assign cdb_in_range   = (bus.cdb_tag != 5'd0) && (bus.cdb_tag <= 5'(ROB_SIZE));
   assign cdb_idx        = IDX_W'(bus.cdb_tag - 5'd1);
   assign query_in_range = (bus.query_tag != 5'd0) && (bus.query_tag <= 5'(ROB_SIZE));
   assign query_idx      = IDX_W'(bus.query_tag - 5'd1);

   assign head_nxt = (head_q == IDX_W'(ROB_SIZE - 1)) ? '0 : head_q + IDX_W'(1);
   assign tail_nxt = (tail_q == IDX_W'(ROB_SIZE - 1)) ? '0 : tail_q + IDX_W'(1);

   // FSM next state and per-cycle action decode; rdy low suppresses every action
   always_comb begin
      state_d = state_q;
      alloc   = 1'b0;
      commit  = 1'b0;
      cdb_hit = 1'b0;
      flush   = 1'b0;
      if (rdy) begin
         unique case (state_q)
            StRun: begin
               alloc   = bus.issue_valid && !bus.rob_full;
               cdb_hit = bus.cdb_valid && cdb_in_range && busy_q[cdb_idx];
               commit  = busy_q[head_q] && ready_q[head_q];
               if (commit && mispred_q[head_q]) begin
                  state_d = StFlush;
               end
            end
            StFlush: begin
               flush   = 1'b1;
               state_d = StRun;
            end
            default: state_d = StRun;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // Head/tail pointers and occupancy count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc) begin
            tail_q <= tail_nxt;
         end
         if (commit) begin
            head_q <= head_nxt;
         end
         if (alloc && !commit) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!alloc && commit) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // Entry status flags: allocate, write back, retire, flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= '0;
         ready_q   <= '0;
         mispred_q <= '0;
      end else begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if (flush) begin
               busy_q[i]    <= 1'b0;
               ready_q[i]   <= 1'b0;
               mispred_q[i] <= 1'b0;
            end else begin
               if (alloc && (tail_q == IDX_W'(i))) begin
                  busy_q[i]    <= 1'b1;
                  ready_q[i]   <= 1'b0;
                  mispred_q[i] <= 1'b0;
               end
               if (cdb_hit && (cdb_idx == IDX_W'(i))) begin
                  ready_q[i] <= 1'b1;
                  if (is_br_q[i] && bus.cdb_mispredict) begin
                     mispred_q[i] <= 1'b1;
                  end
               end
               // Allocation never targets the head while it is still busy
               if (commit && (head_q == IDX_W'(i))) begin
                  busy_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Entry payload: destination, branch flag, result and recovery target
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
         if (alloc && (tail_q == IDX_W'(i))) begin
            rd_q[i]    <= bus.issue_rd;
            is_br_q[i] <= bus.issue_is_branch;
         end
         if (cdb_hit && (cdb_idx == IDX_W'(i))) begin
            data_q[i] <= bus.cdb_data;
            if (is_br_q[i] && bus.cdb_mispredict) begin
               target_q[i] <= bus.cdb_target;
            end
         end
      end
   end

   // Registered commit and recovery outputs; pulses drop unless re-asserted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rob_valid_q      <= 1'b0;
         dest_q           <= '0;
         dest_depend_q    <= '0;
         rob_data_q       <= '0;
         wrong_commit_q   <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         flush_pc_q       <= '0;
      end else begin
         rob_valid_q      <= 1'b0;
         wrong_commit_q   <= 1'b0;
         redirect_valid_q <= 1'b0;
         if (commit) begin
            rob_valid_q   <= 1'b1;
            dest_q        <= rd_q[head_q];
            dest_depend_q <= 5'(head_q) + 5'd1;
            rob_data_q    <= data_q[head_q];
            // Remember the target so the flush cycle can redirect fetch
            if (mispred_q[head_q]) begin
               flush_pc_q <= target_q[head_q];
            end
         end
         if (flush) begin
            wrong_commit_q   <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= flush_pc_q;
         end
      end
   end

   // Operand lookup with same-cycle CDB bypass
   always_comb begin
      query_ready_c = 1'b0;
      query_data_c  = '0;
      if (query_in_range && busy_q[query_idx]) begin
         if (ready_q[query_idx]) begin
            query_ready_c = 1'b1;
            query_data_c  = data_q[query_idx];
         end else if (bus.cdb_valid && (bus.cdb_tag == bus.query_tag)) begin
            query_ready_c = 1'b1;
            query_data_c  = bus.cdb_data;
         end
      end
   end

   assign bus.query_ready    = query_ready_c;
   assign bus.query_data     = query_data_c;
   assign bus.rob_valid      = rob_valid_q;
   assign bus.dest           = dest_q;
   assign bus.dest_depend    = dest_depend_q;
   assign bus.rob_data       = rob_data_q;
   assign bus.wrong_commit   = wrong_commit_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: expected commits and redirects are
// queued when the completing stimulus is driven and popped when they appear.
module tb_rob_commit_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  tag;
      logic [31:0] data;
   } commit_t;

   commit_t     exp_q[$];
   logic [31:0] flush_q[$];

   rob_commit_ctrl_if bus ();

   rob_commit_ctrl #(
      .ROB_SIZE(16),
      .IDX_W   (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every commit or redirect must match the head of its queue
   task automatic check_outputs();
      commit_t e;
      if (bus.rob_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_commit", 32'(bus.rob_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("dest", 32'(bus.dest), 32'(e.rd));
            chk("dest_depend", 32'(bus.dest_depend), 32'(e.tag));
            chk("rob_data", bus.rob_data, e.data);
         end
      end
      if (bus.wrong_commit === 1'b1) begin
         if (flush_q.size() == 0) begin
            chk("unexpected_flush", 32'(bus.wrong_commit), 32'd0);
         end else begin
            chk("redirect_valid", 32'(bus.redirect_valid), 32'd1);
            chk("redirect_pc", bus.redirect_pc, flush_q.pop_front());
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.issue_valid     = 1'b0;
      bus.issue_rd        = '0;
      bus.issue_is_branch = 1'b0;
      bus.cdb_valid       = 1'b0;
      bus.cdb_tag         = '0;
      bus.cdb_data        = '0;
      bus.cdb_mispredict  = 1'b0;
      bus.cdb_target      = '0;
      bus.query_tag       = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rdy = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic br, input logic [4:0] exp_tag);
      chk("issue_tag", 32'(bus.issue_tag), 32'(exp_tag));
      bus.issue_valid     = 1'b1;
      bus.issue_rd        = rd;
      bus.issue_is_branch = br;
      tick();
      bus.issue_valid     = 1'b0;
   endtask

   task automatic cdb_write(input logic [4:0] tag, input logic [31:0] data, input logic mis,
                            input logic [31:0] tgt);
      bus.cdb_valid      = 1'b1;
      bus.cdb_tag        = tag;
      bus.cdb_data       = data;
      bus.cdb_mispredict = mis;
      bus.cdb_target     = tgt;
      tick();
      bus.cdb_valid      = 1'b0;
      bus.cdb_mispredict = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      bus.query_tag = 5'd1;
      #1;
      chk("rst_issue_tag", 32'(bus.issue_tag), 32'd1);
      chk("rst_rob_full", 32'(bus.rob_full), 32'd0);
      chk("rst_rob_valid", 32'(bus.rob_valid), 32'd0);
      chk("rst_wrong_commit", 32'(bus.wrong_commit), 32'd0);
      chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst_query_ready", 32'(bus.query_ready), 32'd0);
      bus.query_tag = 5'd0;

      // Single issue / complete / commit, two cycles after the CDB
      issue(5'd5, 1'b0, 5'd1);
      exp_q.push_back('{rd: 5'd5, tag: 5'd1, data: 32'hDEAD});
      cdb_write(5'd1, 32'hDEAD, 1'b0, 32'h0);
      chk("t1_no_early_commit", 32'(bus.rob_valid), 32'd0);
      tick();
      chk("t1_commit", 32'(bus.rob_valid), 32'd1);
      tick();
      chk("t1_pulse_one_cycle", 32'(bus.rob_valid), 32'd0);
      chk("t1_issue_tag", 32'(bus.issue_tag), 32'd2);

      // Fill, overflow attempt, wrap of issue_tag, free one slot
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue(5'(i + 1), 1'b0, 5'(i + 1));
      end
      chk("t2_full", 32'(bus.rob_full), 32'd1);
      issue(5'd20, 1'b0, 5'd1);
      chk("t2_still_full", 32'(bus.rob_full), 32'd1);
      chk("t2_tag_held", 32'(bus.issue_tag), 32'd1);
      exp_q.push_back('{rd: 5'd1, tag: 5'd1, data: 32'hA5A5_0001});
      cdb_write(5'd1, 32'hA5A5_0001, 1'b0, 32'h0);
      chk("t2_full_before_commit", 32'(bus.rob_full), 32'd1);
      tick();
      chk("t2_commit", 32'(bus.rob_valid), 32'd1);
      chk("t2_not_full", 32'(bus.rob_full), 32'd0);
      issue(5'd21, 1'b0, 5'd1);
      chk("t2_refull", 32'(bus.rob_full), 32'd1);
      chk("t2_next_tag", 32'(bus.issue_tag), 32'd2);

      // Out-of-order completion, in-order retirement
      do_reset();
      issue(5'd10, 1'b0, 5'd1);
      issue(5'd11, 1'b0, 5'd2);
      issue(5'd12, 1'b0, 5'd3);
      exp_q.push_back('{rd: 5'd10, tag: 5'd1, data: 32'h0000_00A1});
      exp_q.push_back('{rd: 5'd11, tag: 5'd2, data: 32'h0000_00A2});
      exp_q.push_back('{rd: 5'd12, tag: 5'd3, data: 32'h0000_00A3});
      cdb_write(5'd3, 32'h0000_00A3, 1'b0, 32'h0);
      cdb_write(5'd2, 32'h0000_00A2, 1'b0, 32'h0);
      chk("t3_head_waits", 32'(bus.rob_valid), 32'd0);
      cdb_write(5'd1, 32'h0000_00A1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_consecutive_commit", 32'(bus.rob_valid), 32'd1);
      end
      tick();
      chk("t3_drained", 32'(bus.rob_valid), 32'd0);

      // Branch mispredict flush
      do_reset();
      issue(5'd1, 1'b0, 5'd1);
      issue(5'd2, 1'b1, 5'd2);
      issue(5'd3, 1'b0, 5'd3);
      exp_q.push_back('{rd: 5'd1, tag: 5'd1, data: 32'h1111});
      exp_q.push_back('{rd: 5'd2, tag: 5'd2, data: 32'h2222});
      flush_q.push_back(32'h1000);
      cdb_write(5'd1, 32'h1111, 1'b0, 32'h0);
      cdb_write(5'd2, 32'h2222, 1'b1, 32'h1000);
      tick();
      chk("t4_branch_commit", 32'(bus.rob_valid), 32'd1);
      chk("t4_no_flush_yet", 32'(bus.wrong_commit), 32'd0);
      tick();
      chk("t4_wrong_commit", 32'(bus.wrong_commit), 32'd1);
      chk("t4_no_commit_in_flush", 32'(bus.rob_valid), 32'd0);
      tick();
      chk("t4_flush_pulse", 32'(bus.wrong_commit), 32'd0);
      chk("t4_issue_tag", 32'(bus.issue_tag), 32'd1);
      chk("t4_not_full", 32'(bus.rob_full), 32'd0);
      bus.query_tag = 5'd3;
      #1;
      chk("t4_tag3_cleared", 32'(bus.query_ready), 32'd0);
      bus.query_tag = 5'd0;
      cdb_write(5'd3, 32'h3333, 1'b0, 32'h0);
      tick();
      chk("t4_tag3_never_commits", 32'(bus.rob_valid), 32'd0);

      // Operand query with CDB bypass
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(5'(i + 1), 1'b0, 5'(i + 1));
      end
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 5'd4;
      bus.cdb_data  = 32'h1234_5678;
      bus.query_tag = 5'd4;
      #1;
      chk("t5_bypass_ready", 32'(bus.query_ready), 32'd1);
      chk("t5_bypass_data", bus.query_data, 32'h1234_5678);
      bus.query_tag = 5'd0;
      #1;
      chk("t5_tag0_ready", 32'(bus.query_ready), 32'd0);
      chk("t5_tag0_data", bus.query_data, 32'h0);
      tick();
      bus.cdb_valid = 1'b0;
      bus.query_tag = 5'd4;
      #1;
      chk("t5_latched_ready", 32'(bus.query_ready), 32'd1);
      chk("t5_latched_data", bus.query_data, 32'h1234_5678);
      bus.query_tag = 5'd3;
      #1;
      chk("t5_pending_ready", 32'(bus.query_ready), 32'd0);
      bus.query_tag = 5'd0;

      // rdy low stalls a ready head
      do_reset();
      issue(5'd7, 1'b0, 5'd1);
      exp_q.push_back('{rd: 5'd7, tag: 5'd1, data: 32'hBEEF});
      cdb_write(5'd1, 32'hBEEF, 1'b0, 32'h0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_stalled", 32'(bus.rob_valid), 32'd0);
      end
      rdy = 1'b1;
      tick();
      chk("t6_commit_after_rdy", 32'(bus.rob_valid), 32'd1);

      // Reset during the flush cycle suppresses the redirect
      do_reset();
      issue(5'd9, 1'b1, 5'd1);
      exp_q.push_back('{rd: 5'd9, tag: 5'd1, data: 32'h9999});
      cdb_write(5'd1, 32'h9999, 1'b1, 32'h2000);
      tick();
      chk("t7_commit", 32'(bus.rob_valid), 32'd1);
      do_reset();
      chk("t7_no_wrong_commit", 32'(bus.wrong_commit), 32'd0);
      tick();
      chk("t7_still_no_flush", 32'(bus.wrong_commit), 32'd0);
      chk("t7_issue_tag", 32'(bus.issue_tag), 32'd1);

      // Everything queued must have been observed
      chk("commits_outstanding", 32'(exp_q.size()), 32'd0);
      chk("flushes_outstanding", 32'(flush_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
